ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM between the IF (instruction) and EX/MEM (data) requesters
//  of the 5-stage core. Each requester keeps a req/addr_ok/data_ok handshake. Data accesses win by
//  default; a starvation counter forces an instruction grant. Pipeline flush drops in-flight fetches.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and the RAM
//  DATA_W      32  data width; wstrb width is DATA_W/8
//  RAM_LAT     1   RAM read latency in cycles (1..3); depth of the response tag pipe
//  STARVE_MAX  4   consecutive data grants over a waiting inst_req before inst is forced (>=1)
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous reset, active low
//  flush_i      in   1         exception flush from WB; cancels fetches only
//  inst_req     in   1         fetch request (read only)
//  inst_addr    in   ADDR_W    fetch address
//  inst_addr_ok out  1         fetch accepted this cycle
//  inst_data_ok out  1         fetch data valid
//  inst_rdata   out  DATA_W    fetch data
//  data_req     in   1         data request
//  data_wr      in   1         1 = write, 0 = read
//  data_wstrb   in   DATA_W/8  byte write strobes
//  data_addr    in   ADDR_W    data address
//  data_wdata   in   DATA_W    write data
//  data_addr_ok out  1         data request accepted this cycle
//  data_data_ok out  1         data response (read data or write done)
//  data_rdata   out  DATA_W    read data
//  ram_en       out  1         RAM enable
//  ram_we       out  DATA_W/8  RAM byte write enables
//  ram_addr     out  ADDR_W    RAM address
//  ram_wdata    out  DATA_W    RAM write data
//  ram_rdata    in   DATA_W    RAM read data, valid RAM_LAT cycles after ram_en
// BEHAVIOUR
//  - Grant is combinational, one per cycle:
//    force_i = inst_req && !flush_i && starve_cnt==STARVE_MAX.
//    Data is granted if data_req && !force_i.
//    Otherwise inst is granted if inst_req && !flush_i.
//  - The winner's addr_ok is 1. ram_en=1. ram_addr and ram_wdata come from the winner.
//  - ram_we = data_wr ? data_wstrb : 0 for a data grant, 0 for an inst grant. With no grant, ram_* outputs are 0.
//  - A request is accepted only when addr_ok=1. A requester holds req and its payload until then.
//  - Tag pipe: RAM_LAT stages of {vld, own(INST/DATA)}. A grant enters stage 0. At the last stage:
//    vld && own==DATA gives data_data_ok=1. vld && own==INST gives inst_data_ok=1.
//    Both rdata outputs are driven by ram_rdata and are qualified by data_ok.
//    A write's data_ok marks write completion.
//  - Total latency is addr_ok at cycle t, data_ok at t+RAM_LAT. Back-to-back grants run at full throughput.
//    Responses always come back in grant order.
//  - starve_cnt (saturating at STARVE_MAX):
//    increments when inst_req && data is granted;
//    clears when inst is granted, or when inst_req=0 or flush_i=1.
//  - flush_i=1: every stage with own==INST has vld cleared at the clock edge, so no inst_data_ok for
//    those entries. No inst grant in the flush cycle. Data entries and data grants are unaffected.
//    An inst response already due in the flush cycle is still output; IF drops it using its own flush.
//  - Reset (async, any time): all tag vld=0 and starve_cnt=0. All outputs are 0 while rst_n=0.
//    Accesses in flight at reset never produce data_ok after release.
//  - Simultaneous requests with starve_cnt<STARVE_MAX: data wins.
//    At STARVE_MAX, inst wins once, then the counter is 0.
// STRUCTURE
//  - Owner encoding (OWN_INST=0, OWN_DATA=1) and the RAM request bus width macros go in
//    DefineModuleBus.h, next to the other stage-bus widths.
//  - One sub-module: arb_resp_pipe. It is the RAM_LAT-deep {vld,own} shift register with a per-owner
//    kill input and the last-stage decode.
//  - Grant logic, starvation counter and RAM muxing stay in ram_port_arbiter.
// TESTING
//  1. Only inst_req, addr 0x1c00_0000, RAM word 0xDEAD_BEEF, RAM_LAT=1.
//     -> inst_addr_ok in cycle 0; inst_data_ok=1 with rdata 0xDEAD_BEEF in cycle 1; ram_we=0.
//  2. Both requesters held high for 10 cycles, STARVE_MAX=4.
//     -> grant pattern D,D,D,D,I,D,D,D,D,I. No data_ok goes to the wrong owner.
//  3. Data write: wstrb 4'b0011, addr 0x100, wdata 0x1234_5678.
//     -> ram_we=4'b0011, data_data_ok next cycle. A read of 0x100 then returns the lower halfword updated.
//  4. RAM_LAT=3, inst granted at t, flush_i pulsed at t+1.
//     -> no inst_data_ok at t+3; a data read granted at t+1 still gets data_data_ok at t+4.
//  5. rst_n asserted for 1 cycle with 2 accesses in flight.
//     -> all outputs 0 at once, no data_ok after release, starve_cnt 0 (verified by scenario 2 timing).
//  6. data_req held with inst_req=0 for 8 cycles.
//     -> data granted every cycle, starve_cnt stays 0; a later inst_req waits the full STARVE_MAX grants.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared owner encoding and response-tag type for the RAM port arbiter.
// Combinational helper only; no state lives here.
// No flow control of its own.
package ram_port_arbiter_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } own_e;

    typedef struct packed {
        logic vld;
        own_e own;
    } tag_t;

    // A tag advancing one stage loses its valid bit if it is a fetch and a flush is active.
    function automatic tag_t tag_age(input tag_t t, input logic kill_inst);
        tag_age = t;
        if (kill_inst && t.own == OWN_INST) begin
            tag_age.vld = 1'b0;
        end
    endfunction

endpackage

// File: rtl/arb_resp_pipe.sv
// Purpose: RAM_LAT-deep {vld,own} shift register; the last stage decodes which requester gets data_ok.
// Latency: a push at cycle t appears on the response outputs at t+RAM_LAT.
// Backpressure: none; advances every cycle, fetch entries are dropped on kill_inst.
module arb_resp_pipe
    import ram_port_arbiter_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_vld,
    input  own_e push_own,
    input  logic kill_inst,
    output logic inst_rsp,
    output logic data_rsp
);

    tag_t [RAM_LAT-1:0] stg;
    tag_t               last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg[0] <= tag_age(tag_t'{vld: push_vld, own: push_own}, kill_inst);
            for (int i = 1; i < RAM_LAT; i++) begin
                stg[i] <= tag_age(stg[i-1], kill_inst);
            end
        end
    end

    // A fetch already at the last stage is still reported during a flush; IF discards it itself.
    assign last     = stg[RAM_LAT-1];
    assign inst_rsp = last.vld && (last.own == OWN_INST);
    assign data_rsp = last.vld && (last.own == OWN_DATA);

endmodule

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one single-port sync SRAM between IF fetches and EX/MEM data accesses.
// Latency: addr_ok at cycle t, data_ok at t+RAM_LAT; one grant per cycle, in-order responses.
// Backpressure: loser's addr_ok stays low and it holds req; data wins unless a fetch is starved.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_inst;
    logic             gnt_data;
    logic             gnt_inst;
    logic             inst_rsp;
    logic             data_rsp;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        force_inst = inst_req && !flush_i && (starve_cnt == CNT_MAX);
        gnt_data   = rst_n && data_req && !force_inst;
        gnt_inst   = rst_n && !gnt_data && inst_req && !flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!inst_req || flush_i || gnt_inst) begin
            starve_cnt <= '0;
        end else if (gnt_data && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        ram_en       = gnt_data || gnt_inst;
        ram_we       = (gnt_data && data_wr) ? data_wstrb : '0;
        ram_addr     = gnt_data ? data_addr : (gnt_inst ? inst_addr : '0);
        ram_wdata    = gnt_data ? data_wdata : '0;
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
    end

    arb_resp_pipe #(
        .RAM_LAT (RAM_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (ram_en),
        .push_own  (gnt_data ? OWN_DATA : OWN_INST),
        .kill_inst (flush_i),
        .inst_rsp  (inst_rsp),
        .data_rsp  (data_rsp)
    );

    assign inst_data_ok = inst_rsp;
    assign data_data_ok = data_rsp;
    assign inst_rdata   = rst_n ? ram_rdata : '0;
    assign data_rdata   = rst_n ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a RAM_LAT=1 instance checked by a response scoreboard,
// plus a RAM_LAT=3 instance for flush and reset timing.
module tb_ram_port_arbiter;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        a_flush, a_inst_req, a_inst_addr_ok, a_inst_data_ok;
    logic [31:0] a_inst_addr, a_inst_rdata;
    logic        a_data_req, a_data_wr, a_data_addr_ok, a_data_data_ok;
    logic [3:0]  a_data_wstrb, a_ram_we;
    logic [31:0] a_data_addr, a_data_wdata, a_data_rdata;
    logic        a_ram_en;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    logic        b_flush, b_inst_req, b_inst_addr_ok, b_inst_data_ok;
    logic [31:0] b_inst_addr, b_inst_rdata;
    logic        b_data_req, b_data_wr, b_data_addr_ok, b_data_data_ok;
    logic [3:0]  b_data_wstrb, b_ram_we;
    logic [31:0] b_data_addr, b_data_wdata, b_data_rdata;
    logic        b_ram_en;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .inst_req(a_inst_req), .inst_addr(a_inst_addr), .inst_addr_ok(a_inst_addr_ok),
        .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
        .data_req(a_data_req), .data_wr(a_data_wr), .data_wstrb(a_data_wstrb),
        .data_addr(a_data_addr), .data_wdata(a_data_wdata), .data_addr_ok(a_data_addr_ok),
        .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
    );

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr), .inst_addr_ok(b_inst_addr_ok),
        .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
        .data_req(b_data_req), .data_wr(b_data_wr), .data_wstrb(b_data_wstrb),
        .data_addr(b_data_addr), .data_wdata(b_data_wdata), .data_addr_ok(b_data_addr_ok),
        .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // RAM models: A has 1-cycle read latency with byte writes, B a 3-cycle read pipe.
    logic [31:0]       mem_a [256];
    logic [31:0]       mem_b [256];
    logic [31:0]       pa;
    logic [2:0][31:0]  pb;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'h1000_0000 + i;
                mem_b[i] <= 32'h2000_0000 + i;
            end
            mem_a[0]  <= 32'hDEAD_BEEF;
            mem_a[64] <= 32'hAAAA_AAAA;
            mem_b[0]  <= 32'hCAFE_0001;
            mem_b[64] <= 32'h5555_0100;
        end else begin
            if (a_ram_en) begin
                pa <= mem_a[a_ram_addr[9:2]];
                for (int k = 0; k < 4; k++) begin
                    if (a_ram_we[k]) mem_a[a_ram_addr[9:2]][8*k +: 8] <= a_ram_wdata[8*k +: 8];
                end
            end
            pb <= {pb[1:0], mem_b[b_ram_addr[9:2]]};
        end
    end
    assign a_ram_rdata = pa;
    assign b_ram_rdata = pb[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for instance A: expectation pushed at grant, popped at data_ok.
    typedef struct {
        logic        own;
        logic        wr;
        logic [31:0] dat;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] ref_a [256];
    logic [7:0]  idx;

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ref_a[i] = 32'h1000_0000 + i;
            ref_a[0]  = 32'hDEAD_BEEF;
            ref_a[64] = 32'hAAAA_AAAA;
        end
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (a_inst_data_ok || a_data_data_ok) begin
                check_eq("sb_single_rsp", 64'(a_inst_data_ok & a_data_data_ok), 0);
                check_eq("sb_rsp_pending", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("sb_owner", 64'(a_data_data_ok), 64'(e.own));
                    if (!e.wr)
                        check_eq("sb_rdata", a_data_data_ok ? a_data_rdata : a_inst_rdata, e.dat);
                end
            end
            check_eq("sb_single_gnt", 64'(a_inst_addr_ok & a_data_addr_ok), 0);
            if (a_data_addr_ok) begin
                idx = a_data_addr[9:2];
                if (a_data_wr) begin
                    sb.push_back('{own: 1'b1, wr: 1'b1, dat: 32'h0});
                    for (int k = 0; k < 4; k++)
                        if (a_data_wstrb[k]) ref_a[idx][8*k +: 8] = a_data_wdata[8*k +: 8];
                end else begin
                    sb.push_back('{own: 1'b1, wr: 1'b0, dat: ref_a[idx]});
                end
            end else if (a_inst_addr_ok) begin
                sb.push_back('{own: 1'b0, wr: 1'b0, dat: ref_a[a_inst_addr[9:2]]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_all();
        {a_flush, a_inst_req, a_data_req, a_data_wr} = '0;
        {b_flush, b_inst_req, b_data_req, b_data_wr} = '0;
        a_inst_addr = '0; a_data_addr = '0; a_data_wdata = '0; a_data_wstrb = '0;
        b_inst_addr = '0; b_data_addr = '0; b_data_wdata = '0; b_data_wstrb = '0;
    endtask

    task automatic chk_zero(input string tag);
        check_eq({tag, "_a"}, {|a_ram_addr, |a_ram_wdata, |a_inst_rdata, |a_data_rdata, a_inst_addr_ok,
                               a_inst_data_ok, a_data_addr_ok, a_data_data_ok, a_ram_en, |a_ram_we}, 0);
        check_eq({tag, "_b"}, {|b_ram_addr, |b_ram_wdata, |b_inst_rdata, |b_data_rdata, b_inst_addr_ok,
                               b_inst_data_ok, b_data_addr_ok, b_data_data_ok, b_ram_en, |b_ram_we}, 0);
    endtask

    // pat bit i = 1 means an inst grant is required in cycle i, otherwise a data grant.
    task automatic run_pat(input string tag, input int n, input logic [15:0] pat);
        for (int i = 0; i < n; i++) begin
            smp();
            check_eq(tag, {a_inst_addr_ok, a_data_addr_ok}, pat[i] ? 2'b10 : 2'b01);
            check_eq("b_quiet", {b_inst_data_ok, b_data_data_ok}, 0);
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        idle_all();
        #2;
        chk_zero("reset_state");
        repeat (2) cyc();
        preload = 1'b0;
        rst_n   = 1'b1;

        // Single fetch on A.
        cyc();
        a_inst_req = 1'b1; a_inst_addr = 32'h1c00_0000;
        smp();
        check_eq("fetch_addr_ok", 64'(a_inst_addr_ok), 1);
        check_eq("fetch_ram_en", 64'(a_ram_en), 1);
        check_eq("fetch_ram_we", 64'(a_ram_we), 0);
        check_eq("fetch_ram_addr", a_ram_addr, 32'h1c00_0000);
        cyc();
        a_inst_req = 1'b0;
        smp();
        check_eq("fetch_data_ok", 64'(a_inst_data_ok), 1);
        check_eq("fetch_rdata", a_inst_rdata, 32'hDEAD_BEEF);

        // Partial write then read-back on A.
        cyc();
        a_data_req = 1'b1; a_data_wr = 1'b1; a_data_wstrb = 4'b0011;
        a_data_addr = 32'h100; a_data_wdata = 32'h1234_5678;
        smp();
        check_eq("wr_addr_ok", 64'(a_data_addr_ok), 1);
        check_eq("wr_ram_we", 64'(a_ram_we), 4'b0011);
        check_eq("wr_ram_wdata", a_ram_wdata, 32'h1234_5678);
        cyc();
        a_data_req = 1'b0; a_data_wr = 1'b0; a_data_wstrb = '0;
        smp();
        check_eq("wr_data_ok", 64'(a_data_data_ok), 1);
        cyc();
        a_data_req = 1'b1;
        smp();
        check_eq("rd_ram_we", 64'(a_ram_we), 0);
        cyc();
        a_data_req = 1'b0;
        smp();
        check_eq("rd_data_ok", 64'(a_data_data_ok), 1);
        check_eq("rd_merged", a_data_rdata, 32'hAAAA_5678);

        // Plain fetch on B: data_ok exactly three cycles after the grant.
        cyc();
        b_inst_req = 1'b1; b_inst_addr = 32'h1c00_0000;
        smp();
        check_eq("b_fetch_addr_ok", 64'(b_inst_addr_ok), 1);
        cyc(); b_inst_req = 1'b0;
        smp(); check_eq("b_fetch_t1", 64'(b_inst_data_ok), 0);
        cyc(); smp(); check_eq("b_fetch_t2", 64'(b_inst_data_ok), 0);
        cyc(); smp();
        check_eq("b_fetch_t3", 64'(b_inst_data_ok), 1);
        check_eq("b_fetch_rdata", b_inst_rdata, 32'hCAFE_0001);

        // Flush on B kills the in-flight fetch but not a data read.
        cyc();
        b_inst_req = 1'b1;
        smp(); check_eq("fl_inst_gnt", 64'(b_inst_addr_ok), 1);
        cyc();
        b_data_req = 1'b1; b_data_addr = 32'h100; b_flush = 1'b1;
        smp();
        check_eq("fl_data_gnt", {b_inst_addr_ok, b_data_addr_ok}, 2'b01);
        cyc();
        b_data_req = 1'b0;
        smp();
        check_eq("fl_no_inst_gnt", {b_inst_addr_ok, b_ram_en, b_inst_data_ok}, 0);
        cyc();
        b_inst_req = 1'b0; b_flush = 1'b0;
        smp();
        check_eq("fl_killed_t3", {b_inst_data_ok, b_data_data_ok}, 0);
        cyc(); smp();
        check_eq("fl_data_t4", {b_inst_data_ok, b_data_data_ok}, 2'b01);
        check_eq("fl_data_rdata", b_data_rdata, 32'h5555_0100);

        // Reset mid-flight: B has two accesses queued, A's starvation counter is at 2.
        cyc();
        b_data_req = 1'b1; b_data_addr = 32'h100;
        a_inst_req = 1'b1; a_data_req = 1'b1; a_data_addr = 32'h100;
        smp();
        check_eq("rst_pre_b_data", 64'(b_data_addr_ok), 1);
        check_eq("rst_pre_a0", 64'(a_data_addr_ok), 1);
        cyc();
        b_data_req = 1'b0; b_inst_req = 1'b1;
        smp();
        check_eq("rst_pre_b_inst", 64'(b_inst_addr_ok), 1);
        check_eq("rst_pre_a1", 64'(a_data_addr_ok), 1);
        cyc();
        b_inst_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid");
        cyc();
        rst_n = 1'b1;
        run_pat("post_rst_gnt", 10, 16'b10_0001_0000);

        // Data-only traffic keeps the counter at zero; a later fetch waits four grants.
        a_inst_req = 1'b0;
        run_pat("data_only_gnt", 8, 16'h0000);
        a_inst_req = 1'b1;
        run_pat("starve_gnt", 10, 16'b10_0001_0000);

        a_inst_req = 1'b0; a_data_req = 1'b0;
        repeat (4) cyc();
        check_eq("sb_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
